perm_round_iter: RTL

- Iterative round engine of the Ascon permutation.
- Owns the 320-bit state register, the round counter and the handshake FSM.
- Drives the round-constant-added state directly into the combinational substitution layer, and takes back the output of the linear diffusion layer one round per cycle.
- Sits between the cipher mode FSM (upstream) and the sub/diffusion datapath (downstream, combinational loop).

---
 rtl/ascon_pkg.sv | 32 +++
 rtl/perm_round_iter_add_layer.sv | 20 ++
 rtl/perm_round_iter.sv | 110 +++++++++++
 3 files changed

// File: rtl/ascon_pkg.sv
// Shared Ascon types and constants used by the permutation round engine.
//   t_state_array   : 5 x 64-bit Ascon state, index [i] is word xi
//   t_perm_fsm      : handshake FSM states of the iterative round engine
//   ROUND_CONSTANTS : per-round constant added to x2[7:0], index = round index
//   round_const()   : table lookup that returns 0 for indices past the table
package ascon_pkg;

  typedef logic [4:0][63:0] t_state_array;

  localparam int unsigned NUM_ROUNDS_A = 12;
  localparam int unsigned NUM_ROUNDS_B = 6;
  localparam int unsigned NUM_ROUNDS_8 = 8;

  localparam logic [0:11][7:0] ROUND_CONSTANTS = {
    8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B
  };

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } t_perm_fsm;

  function automatic logic [7:0] round_const(input int unsigned r);
    if (r < NUM_ROUNDS_A) begin
      return ROUND_CONSTANTS[r[3:0]];
    end
    return '0;
  endfunction

endpackage

// File: rtl/perm_round_iter_add_layer.sv
// Round-constant addition layer of the Ascon permutation (combinational).
//   state_in  : state register contents
//   round_idx : current round index, selects the constant
//   state_out : state_in with the round constant XORed into x2[7:0]
module add_layer
  import ascon_pkg::*;
#(
  parameter int unsigned ROUND_W = 4
) (
  input  t_state_array         state_in,
  input  logic [ROUND_W-1:0]   round_idx,
  output t_state_array         state_out
);

  always_comb begin
    state_out       = state_in;
    state_out[2][7:0] = state_in[2][7:0] ^ round_const(32'(round_idx));
  end

endmodule

// File: rtl/perm_round_iter.sv
// Iterative Ascon round engine: holds the 320-bit state, the round index and
// the start/result handshake. One round per clock through an external
// combinational substitution + diffusion loop.
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   i_start        : start request, accepted only while o_ready=1
//   i_rounds       : round count (6, 8 or 12; anything else runs 12)
//   i_state        : initial state, sampled with i_start
//   o_ready        : engine idle
//   o_state_sbox   : state register with round constant added, to sub layer
//   i_state_diff   : diffusion layer output, captured every RUN cycle
//   o_round_idx    : current round index, holds its last value when idle
//   o_valid        : result available until accepted by i_out_ready
//   o_state        : permutation result (the state register)
module perm_round_iter
  import ascon_pkg::*;
#(
  parameter int unsigned MAX_ROUNDS = 12,
  parameter int unsigned ROUND_W    = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                i_start,
  input  logic [ROUND_W-1:0]  i_rounds,
  input  t_state_array        i_state,
  output logic                o_ready,
  output t_state_array        o_state_sbox,
  input  t_state_array        i_state_diff,
  output logic [ROUND_W-1:0]  o_round_idx,
  output logic                o_valid,
  input  logic                i_out_ready,
  output t_state_array        o_state
);

  localparam logic [ROUND_W-1:0] LAST_IDX = ROUND_W'(MAX_ROUNDS - 1);

  t_perm_fsm          fsm_q, fsm_d;
  t_state_array       state_q, state_d;
  logic [ROUND_W-1:0] idx_q, idx_d;
  logic [ROUND_W-1:0] nr;
  logic [ROUND_W-1:0] start_idx;

  // Unsupported round counts fall back to the full permutation.
  always_comb begin
    nr = ROUND_W'(MAX_ROUNDS);
    if (i_rounds == ROUND_W'(NUM_ROUNDS_B) ||
        i_rounds == ROUND_W'(NUM_ROUNDS_8) ||
        i_rounds == ROUND_W'(NUM_ROUNDS_A)) begin
      nr = i_rounds;
    end
    start_idx = ROUND_W'(MAX_ROUNDS) - nr;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      idx_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    idx_d   = idx_q;
    o_ready = 1'b0;
    o_valid = 1'b0;
    unique case (fsm_q)
      IDLE: begin
        o_ready = 1'b1;
        if (i_start) begin
          state_d = i_state;
          idx_d   = start_idx;
          fsm_d   = RUN;
        end
      end
      RUN: begin
        state_d = i_state_diff;
        // Index saturates at the last round instead of wrapping.
        if (idx_q == LAST_IDX) begin
          fsm_d = DONE;
        end else begin
          idx_d = idx_q + ROUND_W'(1);
        end
      end
      DONE: begin
        o_valid = 1'b1;
        if (i_out_ready) begin
          fsm_d = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  add_layer #(
    .ROUND_W (ROUND_W)
  ) u_add_layer (
    .state_in  (state_q),
    .round_idx (idx_q),
    .state_out (o_state_sbox)
  );

  assign o_state     = state_q;
  assign o_round_idx = idx_q;

endmodule
